// File: rtl/cpu_core_pkg.sv
// Shared core constants and word/address types.
package cpu_core_pkg;
  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int NREGS_DEF = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xword_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Decode-unit read/issue and writeback-unit write signals of the register file.
interface regfile_mp_if #(
  parameter int XLEN = cpu_core_pkg::XLEN,
  parameter int AW   = cpu_core_pkg::REG_AW,
  parameter int NRD  = 2
);
  logic                     du_stall_i;
  logic                     du_r_enable_i;
  logic [NRD-1:0][AW-1:0]   du_rs_addr_i;
  logic [NRD-1:0][XLEN-1:0] du_rs_rdata_o;
  logic [NRD-1:0]           du_rs_busy_o;
  logic                     du_issue_i;
  logic [AW-1:0]            du_issue_rd_i;
  logic                     wbu_w_enable_i;
  logic [AW-1:0]            wbu_rd_addr_i;
  logic [XLEN-1:0]          wbu_wdata_i;

  modport master (
    output du_stall_i, du_r_enable_i, du_rs_addr_i, du_issue_i, du_issue_rd_i,
           wbu_w_enable_i, wbu_rd_addr_i, wbu_wdata_i,
    input  du_rs_rdata_o, du_rs_busy_o
  );

  modport slave (
    input  du_stall_i, du_r_enable_i, du_rs_addr_i, du_issue_i, du_issue_rd_i,
           wbu_w_enable_i, wbu_rd_addr_i, wbu_wdata_i,
    output du_rs_rdata_o, du_rs_busy_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write busy vector; a set at the same edge as a clear of the same reg wins.
module regfile_scoreboard #(
  parameter int AW     = cpu_core_pkg::REG_AW,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                   clock_i,
  input  logic                   nreset_i,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_addr,
  input  logic                   clr_en,
  input  logic [AW-1:0]          clr_addr,
  input  logic [NRD-1:0][AW-1:0] rs_addr,
  output logic [NRD-1:0]         rs_busy
);
  localparam int   DEPTH = 2 ** AW;
  localparam logic BYP   = (BYPASS != 0);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  always_comb begin
    busy_next = busy_reg;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) busy_reg <= '0;
    else           busy_reg <= busy_next;
  end

  // A value being forwarded this cycle is already available, so it is not busy.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_busy
    assign rs_busy[gi] = busy_reg[rs_addr[gi]]
                         & ~(BYP & clr_en & (clr_addr == rs_addr[gi]));
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD registered read ports, one write port,
// x0 hardwired to zero, optional write-to-read bypass and pending-write scoreboard.
module regfile_mp #(
  parameter int XLEN       = cpu_core_pkg::XLEN,
  parameter int NREGS      = cpu_core_pkg::NREGS_DEF,
  parameter int AW         = cpu_core_pkg::REG_AW,
  parameter int NRD        = 2,
  parameter int BYPASS     = 1,
  parameter int SCOREBOARD = 1
) (
  input  logic  clock_i,
  input  logic  nreset_i,
  regfile_mp_if.slave rf
);
  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

  // Addresses 0 and >= NREGS never hold data.
  function automatic logic in_range(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  logic [XLEN-1:0] regs_reg [DEPTH];
  logic            wr_valid;
  logic            capture;

  assign wr_valid = rf.wbu_w_enable_i & in_range(rf.wbu_rd_addr_i);
  assign capture  = rf.du_r_enable_i & ~rf.du_stall_i;

  // Whole-array clear on reset rules out block RAM; storage is plain flops.
  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      for (int r = 0; r < DEPTH; r++) regs_reg[r] <= '0;
    end else if (wr_valid) begin
      regs_reg[rf.wbu_rd_addr_i] <= rf.wbu_wdata_i;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] rdata_reg;
    logic [XLEN-1:0] rdata_next;

    assign addr = rf.du_rs_addr_i[gi];

    always_comb begin
      rdata_next = '0;
      if (in_range(addr)) begin
        if ((BYPASS != 0) && wr_valid && (rf.wbu_rd_addr_i == addr))
          rdata_next = rf.wbu_wdata_i;
        else
          rdata_next = regs_reg[addr];
      end
    end

    always_ff @(posedge clock_i or negedge nreset_i) begin
      if (!nreset_i)    rdata_reg <= '0;
      else if (capture) rdata_reg <= rdata_next;
    end

    assign rf.du_rs_rdata_o[gi] = rdata_reg;
  end

  if (SCOREBOARD != 0) begin : g_sb
    logic set_en;
    assign set_en = rf.du_issue_i & ~rf.du_stall_i & in_range(rf.du_issue_rd_i);

    regfile_scoreboard #(
      .AW     (AW),
      .NRD    (NRD),
      .BYPASS (BYPASS)
    ) u_scoreboard (
      .clock_i  (clock_i),
      .nreset_i (nreset_i),
      .set_en   (set_en),
      .set_addr (rf.du_issue_rd_i),
      .clr_en   (rf.wbu_w_enable_i),
      .clr_addr (rf.wbu_rd_addr_i),
      .rs_addr  (rf.du_rs_addr_i),
      .rs_busy  (rf.du_rs_busy_o)
    );
  end else begin : g_no_sb
    assign rf.du_rs_busy_o = '0;
  end
endmodule
